regfile_write_stager: RTL and testbench

//  Write-side front end of the latch-based integer register file. Accepts up to NUM_WR commit

---
 rtl/regfile_write_stager.sv | 99 +++++++++
 tb/tb_regfile_write_stager.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_stager.sv
// regfile_write_stager
// Write-side front end of the latch-based integer register file. Commit lanes
// are filtered (x0 dropped, highest lane wins on a clash) and registered into a
// per-register staging bank S1, which drives the latch cells' write enables and
// data for one cycle. Read ports are served from S1 while a value is still in
// flight to the cells, and from the cell outputs otherwise.
module regfile_write_stager #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 4,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_WR-1:0]              wr_valid_i,
  input  logic [NUM_WR*AW-1:0]           wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data_i,
  output logic [NUM_REGS-1:0]            reg_we_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_wdata_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_rdata_i,
  input  logic [NUM_RD*AW-1:0]           rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_o,
  output logic                           idle_o
);

  // S1 staging bank: one valid bit and one data word per register
  logic [NUM_REGS-1:0]                 s1_valid_q, s1_valid_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] s1_data_q, s1_data_d;

  // S1 entries that may reach the cells / bypass this cycle
  logic [NUM_REGS-1:0]                 live_valid;

  // Value each register presents to the read ports this cycle
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_view;

  // Lane filter: scan lanes in ascending order so the highest matching lane wins;
  // register 0 and addresses beyond NUM_REGS never match any S1 slot.
  always_comb begin
    s1_valid_d = '0;
    s1_data_d  = s1_data_q;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_valid_i[k] && (wr_addr_i[k*AW +: AW] == AW'(r))) begin
          s1_valid_d[r] = 1'b1;
          s1_data_d[r]  = wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // S1 register: reloaded every cycle, no hold of pending writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= '0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  // Reset also masks the current S1 contents, so a write captured on the edge
  // before reset is never latched by the cells nor forwarded to readers.
  always_comb begin
    live_valid = rst_i ? '0 : s1_valid_q;
  end

  // Cell drive and status outputs
  always_comb begin
    reg_we_o    = live_valid;
    reg_wdata_o = s1_data_q;
    idle_o      = ~|s1_valid_q;
  end

  // Per-register read view: x0 is hard zero, in-flight values bypass the cells
  always_comb begin
    reg_view = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (r != 0) begin
        reg_view[r] = live_valid[r] ? s1_data_q[r]
                                    : reg_rdata_i[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Read mux: out-of-range addresses match no register and read as zero
  always_comb begin
    rd_data_o = '0;
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (rd_addr_i[j*AW +: AW] == AW'(r)) begin
          rd_data_o[j*DATA_WIDTH +: DATA_WIDTH] = reg_view[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_stager.sv
// Testbench for regfile_write_stager: directed cases followed by random traffic.
// The bench models the latch cells as plain storage and keeps an architectural
// reference model; expected outputs are queued per cycle and checked by a monitor.
module tb_regfile_write_stager;

  localparam int NR  = 32;
  localparam int DW  = 32;
  localparam int NWR = 2;
  localparam int NRD = 4;
  localparam int AW  = 5;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b0;
  logic [NWR-1:0]       wr_valid_i = '0;
  logic [NWR*AW-1:0]    wr_addr_i = '0;
  logic [NWR*DW-1:0]    wr_data_i = '0;
  logic [NR-1:0]        reg_we_o;
  logic [NR*DW-1:0]     reg_wdata_o;
  logic [NR*DW-1:0]     reg_rdata_i;
  logic [NRD*AW-1:0]    rd_addr_i = '0;
  logic [NRD*DW-1:0]    rd_data_o;
  logic                 idle_o;

  regfile_write_stager #(
    .NUM_REGS  (NR),
    .DATA_WIDTH(DW),
    .NUM_WR    (NWR),
    .NUM_RD    (NRD)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .wr_valid_i (wr_valid_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .reg_we_o   (reg_we_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_rdata_i(reg_rdata_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .idle_o     (idle_o)
  );

  always #5 clk = ~clk;

  // Latch cell array: cells start at zero and take the write data on the edge
  // ending a cycle in which their enable is high.
  logic [NR-1:0][DW-1:0] cells = '0;
  assign reg_rdata_i = cells;
  always @(posedge clk) begin
    for (int r = 0; r < NR; r++)
      if (reg_we_o[r]) cells[r] <= reg_wdata_o[r*DW +: DW];
  end

  // Reference model: committed architectural state plus the writes accepted last cycle
  logic [DW-1:0] committed [NR];
  bit            pend_v    [NR];
  logic [DW-1:0] pend_d    [NR];

  typedef struct {
    int                    cyc;
    bit                    chk_idle;
    logic                  idle;
    logic [NR-1:0]         we;
    logic [NR-1:0][DW-1:0] wd;
    logic [NRD-1:0][DW-1:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   first  = 1'b1;

  task automatic check(input string name, input int c, input logic [DW-1:0] got,
                       input logic [DW-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc%0d: got %h expected %h", name, c, got, want);
    end
  endtask

  // One clock cycle of stimulus: drive inputs, queue expectations, advance the model
  task automatic do_cycle(input bit rst, input bit v0, input int a0, input logic [DW-1:0] d0,
                          input bit v1, input int a1, input logic [DW-1:0] d1, input int r0);
    int   rds [NRD];
    int   la  [NWR];
    bit   lv  [NWR];
    logic [DW-1:0] ld [NWR];
    exp_t e;
    @(posedge clk);
    #1;
    rds[0] = r0;
    for (int j = 1; j < NRD; j++) rds[j] = $urandom_range(0, 15);
    lv[0] = v0; la[0] = a0; ld[0] = d0;
    lv[1] = v1; la[1] = a1; ld[1] = d1;
    rst_i      = rst;
    wr_valid_i = {v1, v0};
    wr_addr_i  = {5'(a1), 5'(a0)};
    wr_data_i  = {d1, d0};
    for (int j = 0; j < NRD; j++) rd_addr_i[j*AW +: AW] = 5'(rds[j]);

    e.cyc      = cyc;
    e.chk_idle = !first;
    e.we       = '0;
    e.wd       = '0;
    e.idle     = 1'b1;
    for (int r = 0; r < NR; r++) begin
      if (pend_v[r]) begin
        e.idle = 1'b0;
        if (!rst) begin
          e.we[r] = 1'b1;
          e.wd[r] = pend_d[r];
        end
      end
    end
    for (int j = 0; j < NRD; j++) begin
      if (rds[j] == 0)                   e.rd[j] = '0;
      else if (!rst && pend_v[rds[j]])   e.rd[j] = pend_d[rds[j]];
      else                               e.rd[j] = committed[rds[j]];
    end
    exp_q.push_back(e);

    // End of cycle: last cycle's writes land unless reset discards them;
    // this cycle's lanes are accepted (later lane overrides) unless in reset.
    for (int r = 0; r < NR; r++) begin
      if (!rst && pend_v[r]) committed[r] = pend_d[r];
      pend_v[r] = 1'b0;
    end
    if (!rst) begin
      for (int k = 0; k < NWR; k++) begin
        if (lv[k] && la[k] != 0) begin
          pend_v[la[k]] = 1'b1;
          pend_d[la[k]] = ld[k];
        end
      end
    end
    first = 1'b0;
    cyc++;
  endtask

  task automatic idle_cycle(input int r0);
    do_cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, r0);
  endtask

  // Monitor: compare every queued expectation against the DUT outputs mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int j = 0; j < NRD; j++)
          check($sformatf("rd_data%0d", j), e.cyc, rd_data_o[j*DW +: DW], e.rd[j]);
        check("reg_we", e.cyc, reg_we_o, e.we);
        for (int r = 0; r < NR; r++)
          if (e.we[r]) check($sformatf("reg_wdata%0d", r), e.cyc, reg_wdata_o[r*DW +: DW], e.wd[r]);
        if (e.chk_idle) check("idle", e.cyc, 32'(idle_o), 32'(e.idle));
      end
    end
  end

  initial begin
    for (int r = 0; r < NR; r++) begin
      committed[r] = '0;
      pend_v[r]    = 1'b0;
      pend_d[r]    = '0;
    end

    // Reset held two cycles with lanes active
    do_cycle(1'b1, 1'b1, 5, 32'h1234, 1'b1, 6, 32'h5678, 5);
    do_cycle(1'b1, 1'b1, 5, 32'h1234, 1'b1, 6, 32'h5678, 6);
    idle_cycle(5);

    // Single write to x5
    do_cycle(1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, '0, 5);
    idle_cycle(5);
    idle_cycle(5);

    // Same-cycle conflict on x7
    do_cycle(1'b0, 1'b1, 7, 32'h1111, 1'b1, 7, 32'h2222, 7);
    idle_cycle(7);
    idle_cycle(7);

    // x0 write is dropped
    do_cycle(1'b0, 1'b0, 0, '0, 1'b1, 0, 32'hFFFFFFFF, 0);
    idle_cycle(0);
    idle_cycle(0);

    // Streaming x3 = 1,2,3
    do_cycle(1'b0, 1'b1, 3, 32'd1, 1'b0, 0, '0, 3);
    do_cycle(1'b0, 1'b1, 3, 32'd2, 1'b0, 0, '0, 3);
    do_cycle(1'b0, 1'b1, 3, 32'd3, 1'b0, 0, '0, 3);
    idle_cycle(3);
    idle_cycle(3);

    // Reset mid-flight discards the x9 write
    do_cycle(1'b0, 1'b1, 9, 32'hABCD, 1'b0, 0, '0, 9);
    do_cycle(1'b1, 1'b0, 0, '0, 1'b0, 0, '0, 9);
    idle_cycle(9);
    idle_cycle(9);

    // Random traffic over a small address window to provoke clashes and bypass
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
               1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
               $urandom_range(0, 15));
    end
    idle_cycle(1);
    idle_cycle(2);

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
